avalon_st_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges NUM_SRC Avalon-ST source streams into one Avalon-ST sink stream.
- Grant is taken at packet start and held until the granted source's eop beat is accepted, so packets are never interleaved.
- Sits in front of any shared single-consumer streaming resource (e.g. loopback path, MAC TX).
- Ports use the same signal set as avalon_st_if (vld/rdy/sop/eop/data/empty), flattened per source.

---
 rtl/avalon_st_pkt_arbiter.sv | 126 ++++++++++++
 tb/tb_avalon_st_pkt_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_SRC Avalon-ST sources into one sink,
// locking the grant from the first granted beat until that source's eop beat transfers.
module avalon_st_pkt_arbiter #(
    parameter int unsigned  NUM_SRC    = 4,
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned EMPTY_W    = $clog2(DATA_WIDTH),
    localparam int unsigned IDX_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            in_vld,
    output logic [NUM_SRC-1:0]            in_rdy,
    input  logic [NUM_SRC-1:0]            in_sop,
    input  logic [NUM_SRC-1:0]            in_eop,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_SRC*EMPTY_W-1:0]    in_empty,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [EMPTY_W-1:0]            out_empty,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);

    typedef enum logic {StIdle, StLock} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    int unsigned            cand;
    logic [IDX_W-1:0]       cand_idx;
    logic                   sel_vld, sel_sop, sel_eop;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [EMPTY_W-1:0]     sel_empty;

    // Scan starts one past the previous packet owner so every requester is reached in turn.
    always_comb begin
        pick_idx   = last_q;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand     = (32'(last_q) + i) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (!pick_found && in_vld[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_vld   = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        sel_empty = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_vld   = in_vld[i];
                sel_sop   = in_sop[i];
                sel_eop   = in_eop[i];
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        in_rdy    = '0;
        out_vld   = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        out_empty = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = StLock;
                end
            end
            StLock: begin
                out_vld   = sel_vld;
                out_sop   = sel_sop;
                out_eop   = sel_eop;
                out_data  = sel_data;
                out_empty = sel_empty;
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == IDX_W'(i)) begin
                        in_rdy[i] = out_rdy;
                    end
                end
                if (sel_vld && out_rdy && sel_eop) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // last_q resets to the top index so source 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == StLock);

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Scoreboard bench for avalon_st_pkt_arbiter: per-source packet queues drive the inputs,
// expected sink beats are queued in arbitration order and compared as they leave the DUT.
module tb_avalon_st_pkt_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int EW = 5;

    typedef struct packed {
        logic [1:0]  src;
        logic        sop;
        logic        eop;
        logic [4:0]  empty;
        logic [31:0] data;
        logic [3:0]  gap;
    } beat_t;

    logic               clk;
    logic               rst_n;
    logic [NS-1:0]      in_vld = '0;
    logic [NS-1:0]      in_rdy;
    logic [NS-1:0]      in_sop = '0;
    logic [NS-1:0]      in_eop = '0;
    logic [NS*DW-1:0]   in_data = '0;
    logic [NS*EW-1:0]   in_empty = '0;
    logic               out_vld;
    logic               out_rdy = 1'b1;
    logic               out_sop;
    logic               out_eop;
    logic [DW-1:0]      out_data;
    logic [EW-1:0]      out_empty;
    logic [1:0]         grant_idx;
    logic               busy;

    beat_t              src_q [NS][$];
    beat_t              exp_q [$];
    logic [NS-1:0]      xfer = '0;
    bit                 rdy_toggle = 1'b0;
    bit                 eop_pend = 1'b0;
    int                 beats_seen = 0;
    int                 n_checks = 0;
    int                 n_fail = 0;

    avalon_st_pkt_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data   (in_data),
        .in_empty  (in_empty),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_data  (out_data),
        .out_empty (out_empty),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_pkt(input int src, input int nbeats, input logic [31:0] base,
                            input logic [4:0] last_empty, input int gap_beat, input int gap_len);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.src   = 2'(src);
            b.sop   = (k == 0);
            b.eop   = (k == nbeats - 1);
            b.empty = b.eop ? last_empty : 5'd0;
            b.data  = base + 32'(k);
            b.gap   = (k == gap_beat) ? 4'(gap_len) : 4'd0;
            src_q[src].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0);
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #1;
            done = all_empty();
        end
        check_eq(tag, 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Source models: advance on a transfer seen at the previous negedge, hold data otherwise.
    always begin
        beat_t b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (rst_n && xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            in_vld[i] = 1'b0;
            in_sop[i] = 1'b0;
            in_eop[i] = 1'b0;
            in_data[i*DW +: DW] = '0;
            in_empty[i*EW +: EW] = '0;
            if (src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                in_sop[i] = b.sop;
                in_eop[i] = b.eop;
                in_data[i*DW +: DW] = b.data;
                in_empty[i*EW +: EW] = b.empty;
                if (b.gap != 0) b.gap = b.gap - 4'd1;
                else in_vld[i] = 1'b1;
                src_q[i].push_front(b);
            end
        end
        out_rdy = rdy_toggle ? ~out_rdy : 1'b1;
    end

    always @(negedge clk) begin
        beat_t e;
        xfer = in_vld & in_rdy;
        if (eop_pend) begin
            check_eq("idle_after_eop_busy", 64'(busy), 64'd0);
            check_eq("idle_after_eop_vld", 64'(out_vld), 64'd0);
        end
        eop_pend = 1'b0;
        if (busy) begin
            check_eq("rdy_mask", 64'(in_rdy), 64'(4'(out_rdy) << grant_idx));
        end else begin
            check_eq("idle_rdy", 64'(in_rdy), 64'd0);
            check_eq("idle_vld", 64'(out_vld), 64'd0);
        end
        if (out_vld && out_rdy) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(out_data), 64'hdead);
            end else begin
                e = exp_q.pop_front();
                check_eq("grant", 64'(grant_idx), 64'(e.src));
                check_eq("data", 64'(out_data), 64'(e.data));
                check_eq("sop", 64'(out_sop), 64'(e.sop));
                check_eq("eop", 64'(out_eop), 64'(e.eop));
                check_eq("empty", 64'(out_empty), 64'(e.empty));
            end
            if (out_eop) eop_pend = 1'b1;
        end
    end

    initial begin
        int base;
        rst_n = 1'b0;
        #3;
        check_eq("rst_vld", 64'(out_vld), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_grant", 64'(grant_idx), 64'd0);
        check_eq("rst_rdy", 64'(in_rdy), 64'd0);
        check_eq("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        check_eq("rst_data", 64'({out_data, out_empty}), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round robin from reset: order 0,1,2,3,0,1,2,3.
        #1;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < NS; s++)
                send_pkt(s, 2, 32'h1000 * (s + 1) + 32'h10 * k, 5'd0, -1, 0);
        wait_done("drain_rr", 300);

        // Single-beat packets, empty=3: order 0,3,0,3.
        #1;
        send_pkt(0, 1, 32'h2000, 5'd3, -1, 0);
        send_pkt(3, 1, 32'h2300, 5'd3, -1, 0);
        send_pkt(0, 1, 32'h2001, 5'd3, -1, 0);
        send_pkt(3, 1, 32'h2301, 5'd3, -1, 0);
        wait_done("drain_single", 200);

        // last_grant=3 with src0 and src2 requesting: src0 then src2.
        #1;
        send_pkt(0, 2, 32'h3000, 5'd1, -1, 0);
        send_pkt(2, 2, 32'h3200, 5'd2, -1, 0);
        wait_done("drain_wrap", 200);

        // Lone src2 3-beat packet with exact cycle timing.
        #1;
        send_pkt(2, 3, 32'hA0, 5'd0, -1, 0);
        @(negedge clk);
        #1;
        check_eq("t1_bubble_req", 64'(in_vld[2]), 64'd1);
        check_eq("t1_bubble_vld", 64'(out_vld), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_eq("t1_busy", 64'(busy), 64'd1);
            check_eq("t1_grant", 64'(grant_idx), 64'd2);
            check_eq("t1_vld", 64'(out_vld), 64'd1);
            check_eq("t1_data", 64'(out_data), 64'(32'hA0 + 32'(k)));
            check_eq("t1_sop", 64'(out_sop), 64'(k == 0));
            check_eq("t1_eop", 64'(out_eop), 64'(k == 2));
        end
        @(negedge clk);
        #1;
        check_eq("t1_busy_drop", 64'(busy), 64'd0);
        check_eq("t1_grant_hold", 64'(grant_idx), 64'd2);
        wait_done("drain_t1", 50);

        // Backpressure toggling plus a 2-cycle valid gap on src1; src2 waits behind it.
        #1;
        rdy_toggle = 1'b1;
        send_pkt(1, 4, 32'h4100, 5'd2, 2, 2);
        send_pkt(2, 2, 32'h4200, 5'd0, -1, 0);
        wait_done("drain_bp", 300);
        rdy_toggle = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a 4-beat src2 packet.
        #1;
        base = beats_seen;
        send_pkt(2, 4, 32'h5200, 5'd0, -1, 0);
        for (int c = 0; c < 50 && beats_seen < base + 2; c++) begin
            @(negedge clk);
            #1;
        end
        check_eq("t6_reached_beat2", 64'(beats_seen >= base + 2), 64'd1);
        @(posedge clk);
        #3;
        check_eq("t6_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_vld", 64'(out_vld), 64'd0);
        check_eq("t6_async_rdy", 64'(in_rdy), 64'd0);
        check_eq("t6_async_busy", 64'(busy), 64'd0);
        check_eq("t6_async_grant", 64'(grant_idx), 64'd0);
        src_q[2].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        send_pkt(1, 2, 32'h6100, 5'd0, -1, 0);
        send_pkt(3, 1, 32'h6300, 5'd0, -1, 0);
        @(negedge clk);
        #1;
        check_eq("t6_bubble", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        check_eq("t6_regrant_busy", 64'(busy), 64'd1);
        check_eq("t6_regrant_idx", 64'(grant_idx), 64'd1);
        wait_done("drain_t6", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
